// File: rtl/uart_host_pkg.sv
// Shared types and constants for the host-side UART command engine.
package uart_host_pkg;

    // Command engine sequencing states
    typedef enum logic [1:0] {
        StIdle,
        StTxLoad,
        StTxWait,
        StRxWait
    } host_state_e;

    // Single-byte replies from the DSO core
    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    // Command opcodes, carried in the most significant command byte
    localparam logic [7:0] OP_CFG_GAIN  = 8'h02;
    localparam logic [7:0] OP_CFG_TRIG  = 8'h03;
    localparam logic [7:0] OP_CFG_TBASE = 8'h04;
    localparam logic [7:0] OP_ARM       = 8'h05;
    localparam logic [7:0] OP_STATUS    = 8'h06;
    localparam logic [7:0] OP_DUMP_CH   = 8'h07;
    localparam logic [7:0] OP_EEP_WR    = 8'h08;
    localparam logic [7:0] OP_EEP_RD    = 8'h09;

    // Width of a byte counter able to hold 0..depth inclusive
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous byte FIFO holding response bytes until the host pops them.
// A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module resp_fifo
    import uart_host_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [7:0]                  wdata,
    input  logic                        pop,
    output logic [7:0]                  rdata,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head of queue; forced to zero when empty so stale storage never shows
    always_comb begin
        rdata = 8'h00;
        if (!empty) begin
            rdata = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/uart_cmd_host.sv
// Host-side command engine: sends a CMD_BYTES command MSB byte first through a
// byte UART transmitter, then gathers resp_len response bytes into a FIFO with
// an inter-byte timeout and sticky overflow flag.
module uart_cmd_host
    import uart_host_pkg::*;
#(
    parameter int unsigned CMD_BYTES   = 3,
    parameter int unsigned RESP_DEPTH  = 16,
    parameter int unsigned TIMEOUT_CYC = 2 ** 20,
    localparam int unsigned RL_W       = cnt_width(RESP_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*CMD_BYTES-1:0] cmd,
    input  logic [RL_W-1:0]        resp_len,
    input  logic                   send_cmd,
    output logic                   busy,
    output logic                   cmd_sent,
    output logic [7:0]             tx_data,
    output logic                   trmt,
    input  logic                   tx_done,
    input  logic [7:0]             rx_data,
    input  logic                   rx_rdy,
    output logic                   clr_rx_rdy,
    output logic [7:0]             resp_data,
    output logic                   resp_valid,
    input  logic                   resp_pop,
    output logic                   resp_done,
    output logic                   timeout,
    output logic                   overflow
);

    localparam int unsigned IDX_W = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

    host_state_e            state_q, state_d;
    logic [8*CMD_BYTES-1:0] cmd_q, cmd_d;
    logic [RL_W-1:0]        resp_len_q, resp_len_d;
    logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
    logic [RL_W-1:0]        rcv_cnt_q, rcv_cnt_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                   overflow_q, overflow_d;
    logic                   clr_q, clr_d;
    logic                   clr_prev_q;
    logic                   cmd_sent_q, cmd_sent_d;
    logic                   resp_done_q, resp_done_d;
    logic                   timeout_q, timeout_d;

    logic                   rx_take;
    logic                   fifo_push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_drop;
    logic [RL_W-1:0]        fifo_count;
    logic                   unused_fifo_count;

    // rx_rdy stays high for a cycle or two after our clear; ignore it until the clear has landed
    assign rx_take   = rx_rdy && !clr_q && !clr_prev_q;
    assign fifo_push = (state_q == StRxWait) && rx_take;
    assign fifo_drop = fifo_push && fifo_full && !resp_pop;

    assign unused_fifo_count = ^fifo_count;

    resp_fifo #(
        .DEPTH(RESP_DEPTH)
    ) u_resp_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .wdata(rx_data),
        .pop  (resp_pop),
        .rdata(resp_data),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    // Next-state logic for sequencing, counters and event pulses
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        resp_len_d  = resp_len_q;
        byte_idx_d  = byte_idx_q;
        rcv_cnt_d   = rcv_cnt_q;
        tmo_cnt_d   = '0;
        overflow_d  = overflow_q;
        clr_d       = rx_take;
        cmd_sent_d  = 1'b0;
        resp_done_d = 1'b0;
        timeout_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (send_cmd) begin
                    cmd_d      = cmd;
                    resp_len_d = resp_len;
                    overflow_d = 1'b0;
                    byte_idx_d = IDX_W'(CMD_BYTES - 1);
                    rcv_cnt_d  = '0;
                    state_d    = StTxLoad;
                end
            end
            StTxLoad: begin
                state_d = StTxWait;
            end
            StTxWait: begin
                if (tx_done) begin
                    if (byte_idx_q != '0) begin
                        byte_idx_d = byte_idx_q - 1'b1;
                        state_d    = StTxLoad;
                    end else begin
                        cmd_sent_d = 1'b1;
                        if (resp_len_q == '0) begin
                            resp_done_d = 1'b1;
                            state_d     = StIdle;
                        end else begin
                            state_d = StRxWait;
                        end
                    end
                end
            end
            StRxWait: begin
                if (fifo_push) begin
                    // A dropped byte still counts toward the expected length
                    rcv_cnt_d = rcv_cnt_q + 1'b1;
                    if (fifo_drop) begin
                        overflow_d = 1'b1;
                    end
                    if (rcv_cnt_q + 1'b1 == resp_len_q) begin
                        resp_done_d = 1'b1;
                        state_d     = StIdle;
                    end
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and pulse registers; synchronous reset aborts any transfer silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            resp_len_q  <= '0;
            byte_idx_q  <= '0;
            rcv_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            clr_q       <= 1'b0;
            clr_prev_q  <= 1'b0;
            cmd_sent_q  <= 1'b0;
            resp_done_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            resp_len_q  <= resp_len_d;
            byte_idx_q  <= byte_idx_d;
            rcv_cnt_q   <= rcv_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            overflow_q  <= overflow_d;
            clr_q       <= clr_d;
            clr_prev_q  <= clr_q;
            cmd_sent_q  <= cmd_sent_d;
            resp_done_q <= resp_done_d;
            timeout_q   <= timeout_d;
        end
    end

    // Output decode; the current byte is held for the whole TX_LOAD/TX_WAIT window
    always_comb begin
        tx_data = 8'h00;
        if (state_q == StTxLoad || state_q == StTxWait) begin
            tx_data = cmd_q[{byte_idx_q, 3'b000} +: 8];
        end
        busy       = (state_q != StIdle);
        trmt       = (state_q == StTxLoad);
        clr_rx_rdy = clr_q;
        cmd_sent   = cmd_sent_q;
        resp_done  = resp_done_q;
        timeout    = timeout_q;
        overflow   = overflow_q;
        resp_valid = !fifo_empty;
    end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed bench for uart_cmd_host with a small UART transmitter/receiver model.
module tb_uart_cmd_host;

    localparam int unsigned CMD_BYTES   = 3;
    localparam int unsigned RESP_DEPTH  = 4;
    localparam int unsigned TIMEOUT_CYC = 64;
    localparam int unsigned RL_W        = $clog2(RESP_DEPTH) + 1;

    logic                   clk;
    logic                   rst;
    logic [8*CMD_BYTES-1:0] cmd;
    logic [RL_W-1:0]        resp_len;
    logic                   send_cmd;
    logic                   busy;
    logic                   cmd_sent;
    logic [7:0]             tx_data;
    logic                   trmt;
    logic                   tx_done;
    logic [7:0]             rx_data;
    logic                   rx_rdy;
    logic                   clr_rx_rdy;
    logic [7:0]             resp_data;
    logic                   resp_valid;
    logic                   resp_pop;
    logic                   resp_done;
    logic                   timeout;
    logic                   overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Model bookkeeping, written only by the bfm process
    int         cyc           = 0;
    int         trmt_cnt      = 0;
    int         cmd_sent_cnt  = 0;
    int         resp_done_cnt = 0;
    int         timeout_cnt   = 0;
    int         same_cnt      = 0;
    int         cmd_sent_cyc  = 0;
    int         timeout_cyc   = 0;
    int         tx_cd         = 0;
    logic [7:0] tx_log [$];
    logic [7:0] rx_q [$];

    uart_cmd_host #(
        .CMD_BYTES  (CMD_BYTES),
        .RESP_DEPTH (RESP_DEPTH),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd),
        .resp_len  (resp_len),
        .send_cmd  (send_cmd),
        .busy      (busy),
        .cmd_sent  (cmd_sent),
        .tx_data   (tx_data),
        .trmt      (trmt),
        .tx_done   (tx_done),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .clr_rx_rdy(clr_rx_rdy),
        .resp_data (resp_data),
        .resp_valid(resp_valid),
        .resp_pop  (resp_pop),
        .resp_done (resp_done),
        .timeout   (timeout),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmitter/receiver model plus event monitor, all on the falling edge
    initial begin : bfm
        tx_done = 1'b0;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            tx_done = 1'b0;
            if (rst === 1'b1) begin
                tx_cd  = 0;
                rx_rdy = 1'b0;
            end else begin
                if (tx_cd != 0) begin
                    tx_cd--;
                    if (tx_cd == 0) tx_done = 1'b1;
                end
                if (trmt === 1'b1) begin
                    tx_log.push_back(tx_data);
                    trmt_cnt++;
                    tx_cd = 3;
                end
                if (clr_rx_rdy === 1'b1) rx_rdy = 1'b0;
                if (!rx_rdy && rx_q.size() != 0) begin
                    rx_data = rx_q.pop_front();
                    rx_rdy  = 1'b1;
                end
            end
            if (cmd_sent === 1'b1) begin
                cmd_sent_cnt++;
                cmd_sent_cyc = cyc;
            end
            if (resp_done === 1'b1) resp_done_cnt++;
            if (timeout === 1'b1) begin
                timeout_cnt++;
                timeout_cyc = cyc;
            end
            if (cmd_sent === 1'b1 && resp_done === 1'b1) same_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int ev_cnt(input int sel);
        case (sel)
            0:       return cmd_sent_cnt;
            1:       return resp_done_cnt;
            2:       return timeout_cnt;
            default: return trmt_cnt;
        endcase
    endfunction

    // Bounded wait for a monitored event count; an expired budget is a failure
    task automatic wait_ev(input int sel, input int target, input int budget, input string name);
        int n;
        n = 0;
        while (ev_cnt(sel) < target && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (ev_cnt(sel) < target) begin
            n_fail++;
            $display("FAIL wait_%s: count %0d, required %0d within %0d cycles",
                     name, ev_cnt(sel), target, budget);
        end
    endtask

    function automatic logic [23:0] tx_word(input int base);
        logic [23:0] w;
        w = 'x;
        if (tx_log.size() >= base + 3) w = {tx_log[base], tx_log[base+1], tx_log[base+2]};
        return w;
    endfunction

    task automatic start_cmd(input logic [23:0] c, input logic [RL_W-1:0] len);
        cmd      = c;
        resp_len = len;
        send_cmd = 1'b1;
        tick();
        send_cmd = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        cmd      = '0;
        resp_len = '0;
        send_cmd = 1'b0;
        resp_pop = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks += 6;
        if ({busy, trmt, cmd_sent} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: busy/trmt/cmd_sent %b, required 000", {busy, trmt, cmd_sent});
        end
        if (tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_tx_data: got %h, required 00", tx_data);
        end
        if ({resp_valid, resp_done, timeout} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_resp: valid/done/timeout %b, required 000",
                     {resp_valid, resp_done, timeout});
        end
        if (resp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_resp_data: got %h, required 00", resp_data);
        end
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_overflow: got %b, required 0", overflow);
        end
        if (clr_rx_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clr_rx_rdy: got %b, required 0", clr_rx_rdy);
        end
    endtask

    task automatic test_single_ack();
        int b_tx, b_trmt, b_cs, b_rd;
        b_tx = tx_log.size(); b_trmt = trmt_cnt; b_cs = cmd_sent_cnt; b_rd = resp_done_cnt;
        start_cmd(24'h02_0300, 3'd1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_busy_after_accept: got %b, required 1", busy);
        end
        wait_ev(0, b_cs + 1, 100, "ack_cmd_sent");
        n_checks += 2;
        if (trmt_cnt - b_trmt != 3) begin
            n_fail++;
            $display("FAIL ack_trmt_count: got %0d, required 3", trmt_cnt - b_trmt);
        end
        if (tx_word(b_tx) !== 24'h02_0300) begin
            n_fail++;
            $display("FAIL ack_tx_bytes: got %h, required 020300", tx_word(b_tx));
        end
        rx_q.push_back(8'hA5);
        wait_ev(1, b_rd + 1, 50, "ack_resp_done");
        n_checks += 2;
        if ({busy, resp_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL ack_done_state: busy/valid %b, required 01", {busy, resp_valid});
        end
        if (resp_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL ack_resp_data: got %h, required a5", resp_data);
        end
        resp_pop = 1'b1;
        tick();
        resp_pop = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_empty_after_pop: valid %b, required 0", resp_valid);
        end
    endtask

    task automatic test_two_byte();
        int b_tx, b_cs, b_rd;
        b_tx = tx_log.size(); b_cs = cmd_sent_cnt; b_rd = resp_done_cnt;
        start_cmd(24'h09_1200, 3'd2);
        wait_ev(0, b_cs + 1, 100, "two_cmd_sent");
        n_checks++;
        if (tx_word(b_tx) !== 24'h09_1200) begin
            n_fail++;
            $display("FAIL two_tx_bytes: got %h, required 091200", tx_word(b_tx));
        end
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h34);
        wait_ev(1, b_rd + 1, 50, "two_resp_done");
        n_checks += 2;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL two_busy_after_done: got %b, required 0", busy);
        end
        if (resp_data !== 8'hA5 || resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL two_first_byte: got %h valid %b, required a5 valid 1", resp_data, resp_valid);
        end
        resp_pop = 1'b1;
        tick();
        n_checks++;
        if (resp_data !== 8'h34 || resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL two_second_byte: got %h valid %b, required 34 valid 1", resp_data, resp_valid);
        end
        tick();
        resp_pop = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL two_empty: valid %b, required 0", resp_valid);
        end
    endtask

    task automatic test_timeout();
        int b_cs, b_rd, b_to;
        b_cs = cmd_sent_cnt; b_rd = resp_done_cnt; b_to = timeout_cnt;
        start_cmd(24'h06_0000, 3'd1);
        wait_ev(0, b_cs + 1, 100, "tmo_cmd_sent");
        wait_ev(2, b_to + 1, 100, "tmo_timeout");
        n_checks += 3;
        if (timeout_cyc - cmd_sent_cyc != 64) begin
            n_fail++;
            $display("FAIL tmo_latency: got %0d cycles, required 64", timeout_cyc - cmd_sent_cyc);
        end
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_busy: got %b, required 0", busy);
        end
        if (resp_done_cnt != b_rd || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_no_resp: done pulses %0d valid %b, required 0 and 0",
                     resp_done_cnt - b_rd, resp_valid);
        end
    endtask

    task automatic test_overflow();
        int b_cs, b_rd;
        logic [7:0] exp;
        b_cs = cmd_sent_cnt; b_rd = resp_done_cnt;
        start_cmd(24'h07_0100, 3'd6);
        wait_ev(0, b_cs + 1, 100, "ovf_cmd_sent");
        for (int i = 0; i < 6; i++) rx_q.push_back(8'h11 + 8'(i));
        wait_ev(1, b_rd + 1, 100, "ovf_resp_done");
        n_checks += 2;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: got %b, required 1", overflow);
        end
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_busy: got %b, required 0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 8'h11 + 8'(i);
            n_checks++;
            if (resp_valid !== 1'b1 || resp_data !== exp) begin
                n_fail++;
                $display("FAIL ovf_kept_%0d: got %h valid %b, required %h valid 1",
                         i, resp_data, resp_valid, exp);
            end
            resp_pop = 1'b1;
            tick();
            resp_pop = 1'b0;
        end
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_only_four: valid %b, required 0", resp_valid);
        end
        b_rd = resp_done_cnt;
        start_cmd(24'h05_0000, 3'd0);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear_on_send: got %b, required 0", overflow);
        end
        wait_ev(1, b_rd + 1, 100, "ovf_next_done");
    endtask

    task automatic test_back_to_back();
        int b_tx, b_trmt, b_cs, b_rd, b_same;
        b_tx = tx_log.size(); b_trmt = trmt_cnt; b_cs = cmd_sent_cnt;
        b_rd = resp_done_cnt; b_same = same_cnt;
        start_cmd(24'h08_0000, 3'd0);
        tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy: got %b, required 1", busy);
        end
        cmd      = 24'h09_0000;
        resp_len = 3'd1;
        send_cmd = 1'b1;
        tick();
        send_cmd = 1'b0;
        wait_ev(1, b_rd + 1, 100, "b2b_resp_done");
        n_checks++;
        if (same_cnt - b_same != 1) begin
            n_fail++;
            $display("FAIL b2b_same_cycle: coincident pulses %0d, required 1", same_cnt - b_same);
        end
        repeat (30) tick();
        n_checks += 3;
        if (trmt_cnt - b_trmt != 3) begin
            n_fail++;
            $display("FAIL b2b_trmt_count: got %0d, required 3", trmt_cnt - b_trmt);
        end
        if (cmd_sent_cnt - b_cs != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_single_cmd: cmd_sent %0d busy %b, required 1 and 0",
                     cmd_sent_cnt - b_cs, busy);
        end
        if (tx_word(b_tx) !== 24'h08_0000) begin
            n_fail++;
            $display("FAIL b2b_tx_bytes: got %h, required 080000", tx_word(b_tx));
        end
    endtask

    task automatic test_reset_mid();
        int b_trmt, b_cs, b_rd;
        b_cs = cmd_sent_cnt; b_rd = resp_done_cnt;
        start_cmd(24'h03_0000, 3'd1);
        wait_ev(0, b_cs + 1, 100, "mid_pre_cmd_sent");
        rx_q.push_back(8'h5A);
        wait_ev(1, b_rd + 1, 50, "mid_pre_done");
        n_checks++;
        if (resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_fifo_preload: valid %b, required 1", resp_valid);
        end
        b_trmt = trmt_cnt; b_cs = cmd_sent_cnt; b_rd = resp_done_cnt;
        start_cmd(24'h04_0102, 3'd2);
        wait_ev(3, b_trmt + 2, 50, "mid_second_trmt");
        tick();
        rst = 1'b1;
        tick();
        n_checks += 3;
        if ({busy, trmt} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_ctl: busy/trmt %b, required 00", {busy, trmt});
        end
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_fifo: valid %b, required 0", resp_valid);
        end
        if (tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_tx_data: got %h, required 00", tx_data);
        end
        tick();
        rst = 1'b0;
        repeat (20) tick();
        n_checks++;
        if (cmd_sent_cnt != b_cs || resp_done_cnt != b_rd || trmt_cnt - b_trmt != 2) begin
            n_fail++;
            $display("FAIL mid_aborted: cmd_sent %0d done %0d trmt %0d, required 0 0 2",
                     cmd_sent_cnt - b_cs, resp_done_cnt - b_rd, trmt_cnt - b_trmt);
        end
    endtask

    initial begin
        rst      = 1'b1;
        cmd      = '0;
        resp_len = '0;
        send_cmd = 1'b0;
        resp_pop = 1'b0;
        test_reset();
        test_single_ack();
        test_two_byte();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
